digit_entry_ctrl: RTL and testbench

Sequences the keyboard digit decoder so a consumer can request a multi-digit decimal number.
- On a request, it drives the decoder's status enable and takes one digit per accepted key.
- After each digit, it drops status to clear the decoder's control flag.
- After DIGITS digits, it returns the binary value with a one-cycle ack.
- Sits between the PS/2 decode path and the consumer of user input.

---
 rtl/kbd_pkg.sv | 38 +++
 rtl/bcd_accumulate.sv | 25 ++
 rtl/digit_entry_ctrl.sv | 152 +++++++++++++++
 tb/tb_digit_entry_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared keyboard-path definitions.
//   - entry_state_t : states of the digit entry sequencer
//   - DIGIT_MAX     : largest legal decimal digit from the decoder
//   - RELEASE_MIN   : minimum cycles spent with status low after a digit
//   - SC_*          : PS/2 set-2 make codes used by the digit decoder
//   - is_digit()    : range check for a decoded digit
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_KEY = 2'd1,
    RELEASE  = 2'd2,
    DONE     = 2'd3
  } entry_state_t;

  localparam int DIGIT_MAX   = 9;
  localparam int RELEASE_MIN = 2;

  // Make codes for the main-row digit keys.
  localparam logic [7:0] SC_0      = 8'h45;
  localparam logic [7:0] SC_1      = 8'h16;
  localparam logic [7:0] SC_2      = 8'h1E;
  localparam logic [7:0] SC_3      = 8'h26;
  localparam logic [7:0] SC_4      = 8'h25;
  localparam logic [7:0] SC_5      = 8'h2E;
  localparam logic [7:0] SC_6      = 8'h36;
  localparam logic [7:0] SC_7      = 8'h3D;
  localparam logic [7:0] SC_8      = 8'h3E;
  localparam logic [7:0] SC_9      = 8'h46;
  // Prefix bytes: key release and extended key.
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXTEND = 8'hE0;

  function automatic logic is_digit(input logic [3:0] d);
    return (d <= 4'(DIGIT_MAX));
  endfunction

endpackage

// File: rtl/bcd_accumulate.sv
// Combinational decimal accumulate step: next = acc*10 + digit, saturating.
//   acc      [W-1:0] : current accumulated value
//   digit    [3:0]   : decimal digit to append (zero-extended)
//   next_acc [W-1:0] : new value, forced to all-ones when it does not fit
//   sat              : the true result exceeded 2^W-1
module bcd_accumulate #(
  parameter int W = 16
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   digit,
  output logic [W-1:0] next_acc,
  output logic         sat
);

  // Four extra bits hold acc*10 + 15 for any acc, so nothing is lost
  // before the saturation test.
  logic [W+3:0] wide_acc;
  logic [W+3:0] sum;

  assign wide_acc = {4'b0000, acc};
  assign sum      = (wide_acc << 3) + (wide_acc << 1) + {{W{1'b0}}, digit};
  assign sat      = |sum[W+3:W];
  assign next_acc = sat ? {W{1'b1}} : sum[W-1:0];

endmodule

// File: rtl/digit_entry_ctrl.sv
// Digit entry sequencer between the PS/2 digit decoder and a consumer.
// A req in IDLE starts an entry of DIGITS decimal digits; the binary result
// is returned on value with a one-cycle ack.
//
// Decoder handshake: status=1 enables the decoder. The decoder raises
// control with a digit on num and holds both until it sees status=0; it
// clears control one cycle after that. A digit is taken on the first cycle
// control=1 is seen in WAIT_KEY, then status stays low until control has
// fallen and at least RELEASE_MIN cycles have passed.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : start an entry (only honoured in IDLE)
//   cancel       : abort an entry in progress, highest priority
//   control, num : decoder flag and digit
//   status       : decoder enable, high only while waiting for a key
//   busy         : entry in progress (any state but IDLE)
//   ack          : one-cycle pulse, value/overflow hold the new result
//   value        : last completed result, kept until the next completion
//   overflow     : last completed result saturated
//   state_dbg    : current sequencer state
module digit_entry_ctrl
  import kbd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int W      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic         cancel,
  input  logic         control,
  input  logic [3:0]   num,
  output logic         status,
  output logic         busy,
  output logic         ack,
  output logic [W-1:0] value,
  output logic         overflow,
  output entry_state_t state_dbg
);

  localparam logic [3:0] DIGITS_C   = 4'(DIGITS);
  localparam logic [1:0] DWELL_LAST = 2'(RELEASE_MIN - 1);

  entry_state_t state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [1:0]   dwell_q, dwell_d;
  logic [W-1:0] acc_q, acc_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] value_q, value_d;
  logic         overflow_q, overflow_d;

  logic [W-1:0] step_acc;
  logic         step_sat;

  bcd_accumulate #(.W(W)) u_acc (
    .acc      (acc_q),
    .digit    (num),
    .next_acc (step_acc),
    .sat      (step_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dwell_q    <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      value_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dwell_q    <= dwell_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      value_q    <= value_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dwell_d    = dwell_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    value_d    = value_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = WAIT_KEY;
        end
      end

      WAIT_KEY: begin
        // An out-of-range digit is a decoder protocol error: keep waiting.
        if (control && is_digit(num)) begin
          acc_d   = step_acc;
          ovf_d   = ovf_q | step_sat;
          cnt_d   = cnt_q + 4'd1;
          dwell_d = '0;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (!control && (dwell_q >= DWELL_LAST)) begin
          if (cnt_q == DIGITS_C) begin
            // Result is published on entry to DONE so it is valid with ack.
            value_d    = acc_q;
            overflow_d = ovf_q;
            state_d    = DONE;
          end else begin
            state_d = WAIT_KEY;
          end
        end else if (dwell_q != DWELL_LAST) begin
          dwell_d = dwell_q + 2'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over every other transition but leaves the last result.
    if (cancel && (state_q != IDLE)) begin
      state_d    = IDLE;
      value_d    = value_q;
      overflow_d = overflow_q;
    end
  end

  assign status    = (state_q == WAIT_KEY);
  assign busy      = (state_q != IDLE);
  assign ack       = (state_q == DONE);
  assign value     = value_q;
  assign overflow  = overflow_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Bench for digit_entry_ctrl: one instance with DIGITS=4 for the main
// scenarios, a second with DIGITS=5 for the saturation boundaries.
module tb_digit_entry_ctrl;
  import kbd_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         req, cancel, control;
  logic [3:0]   num;
  logic         status, busy, ack, overflow;
  logic [W-1:0] value;
  entry_state_t state_dbg;

  logic         req5, cancel5, control5;
  logic [3:0]   num5;
  logic         status5, busy5, ack5, overflow5;
  logic [W-1:0] value5;
  entry_state_t state_dbg5;

  digit_entry_ctrl #(.DIGITS(4), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cancel(cancel),
    .control(control), .num(num), .status(status), .busy(busy),
    .ack(ack), .value(value), .overflow(overflow), .state_dbg(state_dbg)
  );

  digit_entry_ctrl #(.DIGITS(5), .W(W)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .cancel(cancel5),
    .control(control5), .num(num5), .status(status5), .busy(busy5),
    .ack(ack5), .value(value5), .overflow(overflow5), .state_dbg(state_dbg5)
  );

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];   // {overflow, value} per started entry
  int checks  = 0;
  int errors  = 0;
  int ack_cnt = 0;

  always @(negedge clk) if (ack === 1'b1) ack_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal number from n nibbles (most significant first),
  // clamped to the W-bit range.
  function automatic logic [W:0] model(input logic [35:0] nib, input int n);
    longint v;
    longint maxv;
    v    = 0;
    maxv = (longint'(1) << W) - 1;
    for (int k = 0; k < n; k++) v = v * 10 + longint'(nib[4*(n-1-k) +: 4]);
    if (v > maxv) return {1'b1, {W{1'b1}}};
    return {1'b0, v[W-1:0]};
  endfunction

  // ---------------- driver tasks (enter and leave just after a negedge) ----------------
  task automatic do_req();
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("req_to_status", {31'b0, status}, 32'd1);
    check("req_busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_status();
    int n;
    n = 0;
    while (status !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("status_up_timeout", {31'b0, status}, 32'd1);
  endtask

  // Plays the decoder for one key; hold adds cycles control stays high.
  task automatic enter_digit(input logic [3:0] d, input int hold, input bit last);
    logic [W:0] e;
    wait_status();
    control = 1'b1;
    num     = d;
    @(negedge clk);
    check("capture_status_low", {31'b0, status}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("held_control_waits", {30'b0, status, ack}, 32'd0);
    end
    @(negedge clk);
    check("release_dwell", {31'b0, status}, 32'd0);
    control = 1'b0;
    @(negedge clk);
    if (last) begin
      check("ack_pulse", {31'b0, ack}, 32'd1);
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("value", {16'b0, value}, {16'b0, e[W-1:0]});
        check("overflow", {31'b0, overflow}, {31'b0, e[W]});
      end
      @(negedge clk);
      check("ack_one_cycle", {30'b0, ack, busy}, 32'd0);
    end else begin
      check("back_to_wait_key", {31'b0, status}, 32'd1);
    end
  endtask

  task automatic run_entry(input logic [35:0] nib, input int max_hold);
    int a0;
    a0 = ack_cnt;
    exp_q.push_back(model(nib, 4));
    do_req();
    for (int i = 0; i < 4; i++)
      enter_digit(nib[4*(3-i) +: 4], int'($urandom_range(0, max_hold)), i == 3);
    check("single_ack", ack_cnt - a0, 32'd1);
  endtask

  task automatic entry5(input logic [35:0] nib);
    logic [W:0] e;
    int n;
    e = model(nib, 5);
    req5 = 1'b1;
    @(negedge clk);
    req5 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (status5 !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("d5_status_up", {31'b0, status5}, 32'd1);
      control5 = 1'b1;
      num5     = nib[4*(4-k) +: 4];
      @(negedge clk);
      @(negedge clk);
      control5 = 1'b0;
      @(negedge clk);
    end
    check("d5_ack", {31'b0, ack5}, 32'd1);
    check("d5_value", {16'b0, value5}, {16'b0, e[W-1:0]});
    check("d5_overflow", {31'b0, overflow5}, {31'b0, e[W]});
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int a0;
    logic [35:0] nib;

    rst_n = 1'b0; req = 0; cancel = 0; control = 0; num = 0;
    req5 = 0; cancel5 = 0; control5 = 0; num5 = 0;
    repeat (3) @(negedge clk);
    check("rst_status", {31'b0, status}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_value", {16'b0, value}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_state", {30'b0, state_dbg}, {30'b0, IDLE});
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", {31'b0, busy}, 32'd0);

    // Leading zeros, then back-to-back 1234.
    run_entry(36'h0007, 0);
    run_entry(36'h1234, 0);

    // Cancel mid-entry keeps the previous result.
    a0 = ack_cnt;
    do_req();
    enter_digit(4'd5, 0, 1'b0);
    enter_digit(4'd6, 0, 1'b0);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", {31'b0, busy}, 32'd0);
    check("cancel_status", {31'b0, status}, 32'd0);
    repeat (3) @(negedge clk);
    check("cancel_no_ack", ack_cnt - a0, 32'd0);
    check("cancel_value_kept", {16'b0, value}, 32'd1234);
    run_entry(36'h4321, 1);

    // Cancel in IDLE does nothing; req with cancel in IDLE starts an entry.
    cancel = 1'b1;
    @(negedge clk);
    check("cancel_idle", {31'b0, busy}, 32'd0);
    exp_q.push_back(model(36'h2468, 4));
    req = 1'b1;
    @(negedge clk);
    req = 1'b0; cancel = 1'b0;
    check("req_beats_cancel_idle", {31'b0, status}, 32'd1);
    for (int i = 0; i < 4; i++) enter_digit(4'(2 * (i + 1)), 0, i == 3);

    // req while busy is ignored; out-of-range digit ignored; long hold.
    exp_q.push_back(model(36'h8205, 4));
    do_req();
    enter_digit(4'd8, 0, 1'b0);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("req_busy_ignored", {31'b0, status}, 32'd1);
    control = 1'b1;
    num = 4'd12;
    repeat (3) begin
      @(negedge clk);
      check("bad_digit_ignored", {31'b0, status}, 32'd1);
    end
    enter_digit(4'd2, 10, 1'b0);
    enter_digit(4'd0, 0, 1'b0);
    enter_digit(4'd5, 0, 1'b1);

    // Stale control already high when WAIT_KEY is entered.
    exp_q.push_back(model(36'h3001, 4));
    control = 1'b1;
    num = 4'd3;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("stale_wait_key", {31'b0, status}, 32'd1);
    @(negedge clk);
    check("stale_captured", {31'b0, status}, 32'd0);
    @(negedge clk);
    control = 1'b0;
    @(negedge clk);
    check("stale_next_key", {31'b0, status}, 32'd1);
    enter_digit(4'd0, 0, 1'b0);
    enter_digit(4'd0, 0, 1'b0);
    enter_digit(4'd1, 0, 1'b1);

    // Reset mid-entry clears everything at once.
    do_req();
    enter_digit(4'd7, 0, 1'b0);
    enter_digit(4'd7, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_status", {31'b0, status}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_value", {16'b0, value}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_entry(36'h9876, 0);

    // Random entries with random key hold times and idle gaps.
    for (int r = 0; r < 10; r++) begin
      nib = '0;
      for (int k = 0; k < 4; k++) nib[4*k +: 4] = 4'($urandom_range(0, 9));
      run_entry(nib, 3);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Saturation boundaries on the 5-digit instance.
    entry5(36'h99999);
    entry5(36'h65535);
    entry5(36'h65536);
    entry5(36'h00000);
    for (int r = 0; r < 3; r++) begin
      nib = '0;
      for (int k = 0; k < 5; k++) nib[4*k +: 4] = 4'($urandom_range(0, 9));
      entry5(nib);
    end

    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
